// File: rtl/alu_arbiter.sv
// alu_arbiter -- arbitrates two requesters onto one shared combinational ALU
// and returns the result through a valid/ready response port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rX_valid / rX_ready        request handshake for requester X (0 or 1)
//   rX_a, rX_b, rX_op          operands and ALU control code of requester X
//   alu_a, alu_b, alu_ctrl     operands / control driven to the shared ALU
//   alu_result, alu_overflow,
//   alu_carry, alu_zero,
//   alu_negative               combinational ALU outputs
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     index of the requester the response belongs to
//   rsp_result, rsp_flags      captured result, flags {overflow,carry,zero,negative}
//   rsp_err                    operation carried an illegal opcode
//
// Build option
//   ALU_ARB_RR_EN defined   : round-robin arbitration with a last_grant pointer
//   ALU_ARB_RR_EN undefined : fixed priority, requester 0 always wins
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | latched operation driven on alu_a/alu_b/alu_ctrl, ALU settling
// RESP  | response held on rsp_* until rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             grant_id;
    logic             any_valid;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             sel_legal;
    logic             pend_id;
    logic             pend_err;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = ~r0_valid;
        end
    end
`else
    // Requester 0 wins whenever it is valid.
    assign grant_id = ~r0_valid;
`endif

    assign any_valid = r0_valid | r1_valid;

    // rst_n gating keeps ready low while reset is held even though the
    // state register already reads IDLE.
    assign r0_ready = rst_n && (state == IDLE) && r0_valid && !grant_id;
    assign r1_ready = rst_n && (state == IDLE) && r1_valid &&  grant_id;

    assign sel_a  = grant_id ? r1_a  : r0_a;
    assign sel_b  = grant_id ? r1_b  : r0_b;
    assign sel_op = grant_id ? r1_op : r0_op;

    always_comb begin
        case (sel_op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    // alu_a/alu_b/alu_ctrl double as the operand latch: they load only on
    // accept, so they are steady through EXEC and keep their value after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 3'b000;
            pend_id    <= 1'b0;
            pend_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'b0000;
            rsp_err    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state    <= EXEC;
                        pend_id  <= grant_id;
                        pend_err <= ~sel_legal;
                        if (sel_legal) begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_ctrl <= sel_op;
                        end else begin
                            alu_a    <= '0;
                            alu_b    <= '0;
                            alu_ctrl <= 3'b000;
                        end
`ifdef ALU_ARB_RR_EN
                        last_grant <= grant_id;
`endif
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= pend_id;
                    rsp_err   <= pend_err;
                    // Illegal ops still ran an add of zeros; hide its flags.
                    if (pend_err) begin
                        rsp_result <= '0;
                        rsp_flags  <= 4'b0000;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_overflow, alu_carry, alu_zero, alu_negative};
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

`ifdef ALU_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         r0_valid = 1'b0;
    logic         r1_valid = 1'b0;
    logic [W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0]   r0_op = 3'b000, r1_op = 3'b000;
    logic         r0_ready, r1_ready;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic         alu_overflow, alu_carry, alu_zero, alu_negative;
    logic         rsp_valid, rsp_id, rsp_err;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Shared ALU behaviour: returns {result, overflow, carry, zero, negative}.
    // Carry on subtract means borrow.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W-1:0] r;
        logic ov, cy;
        r = '0; ov = 1'b0; cy = 1'b0;
        case (op)
            OP_ADD: begin
                {cy, r} = {1'b0, a} + {1'b0, b};
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r  = a - b;
                cy = (a < b);
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? W'(1) : '0;
            default: r = '0;
        endcase
        return {r, ov, cy, (r == '0), r[W-1]};
    endfunction

    assign {alu_result, alu_overflow, alu_carry, alu_zero, alu_negative} = alu_fn(alu_a, alu_b, alu_ctrl);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         err;
        logic [W-1:0] da;
        logic [W-1:0] db;
        logic [2:0]   dc;
    } exp_t;

    exp_t         exp_q[$];
    logic         grant_log[$];
    bit           busy = 1'b0;
    int           age = 0;
    logic         mlast = 1'b1;
    logic [W-1:0] ld_a = '0, ld_b = '0;
    logic [2:0]   ld_c = 3'b000;
    int           rsp_count = 0;
    logic         last_id, last_err;
    logic [W-1:0] last_res;
    logic [3:0]   last_flg;
    logic [2:0]   exec_ctrl_seen;

    function automatic exp_t make_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [2:0] op);
        exp_t e;
        e.id = id;
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT}) begin
            {e.res, e.flg} = alu_fn(a, b, op);
            e.err = 1'b0; e.da = a; e.db = b; e.dc = op;
        end else begin
            e.res = '0; e.flg = 4'b0000; e.err = 1'b1; e.da = '0; e.db = '0; e.dc = 3'b000;
        end
        return e;
    endfunction

    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return RR_EN ? !last : 1'b0;
        return !v0;
    endfunction

    always @(negedge clk) begin : monitor
        logic gid, want, exp_rv;
        exp_t e;
        if (!rst_n) begin
            chk("reset_ctrl_outputs", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, rsp_flags, alu_ctrl}, '0);
            chk("reset_rsp_result", rsp_result, '0);
            chk("reset_alu_a", alu_a, '0);
            chk("reset_alu_b", alu_b, '0);
            busy = 1'b0; age = 0; mlast = 1'b1;
            ld_a = '0; ld_b = '0; ld_c = 3'b000;
            exp_q.delete();
        end else begin
            if (busy) age++;
            want = !busy && (r0_valid || r1_valid);
            gid  = pick_grant(r0_valid, r1_valid, mlast);
            chk("r0_ready", r0_ready, want && !gid);
            chk("r1_ready", r1_ready, want && gid);
            exp_rv = busy && (age >= 2);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (busy && age == 1 && exp_q.size() > 0) begin
                chk("exec_alu_a", alu_a, exp_q[0].da);
                chk("exec_alu_b", alu_b, exp_q[0].db);
                chk("exec_alu_ctrl", alu_ctrl, exp_q[0].dc);
                exec_ctrl_seen = alu_ctrl;
                ld_a = exp_q[0].da; ld_b = exp_q[0].db; ld_c = exp_q[0].dc;
            end else begin
                chk("hold_alu_a", alu_a, ld_a);
                chk("hold_alu_b", alu_b, ld_b);
                chk("hold_alu_ctrl", alu_ctrl, ld_c);
            end
            if (exp_rv && rsp_valid && exp_q.size() > 0) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_result", rsp_result, exp_q[0].res);
                chk("rsp_flags", rsp_flags, exp_q[0].flg);
                chk("rsp_err", rsp_err, exp_q[0].err);
            end
            if (exp_rv && rsp_ready) begin
                last_id = rsp_id; last_res = rsp_result; last_flg = rsp_flags; last_err = rsp_err;
                rsp_count++;
                if (exp_q.size() > 0) exp_q.delete(0);
                busy = 1'b0;
            end
            if (want) begin
                e = gid ? make_exp(1'b1, r1_a, r1_b, r1_op) : make_exp(1'b0, r0_a, r0_b, r0_op);
                exp_q.push_back(e);
                grant_log.push_back(gid);
                busy  = 1'b1;
                age   = 0;
                mlast = gid;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit must, input int budget);
        bit got;
        got = 1'b0;
        if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
        else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = id ? r1_ready : r0_ready;
            @(posedge clk); #1;
        end
        if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
        if (must) chk("accept_timeout", got, 1);
    endtask

    task automatic wait_count(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 50) begin @(posedge clk); #1; n++; end
        chk("rsp_timeout", rsp_count >= target, 1);
    endtask

    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int base;
        base = rsp_count;
        issue(id, a, b, op, 1'b1, 20);
        wait_count(base + 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_timeout", busy, 0);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_driver(input logic id);
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            issue(id, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)), 1'b0,
                  ($urandom_range(0, 4) == 0) ? 1 : 30);
        end
    endtask

    bit rand_on = 1'b0;

    initial begin
        int base;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(1'b0, 32'd5, 32'd7, OP_ADD);
        chk("add_id", last_id, 0);
        chk("add_result", last_res, 12);
        chk("add_flags", last_flg, 4'b0000);
        chk("add_err", last_err, 0);

        run_op(1'b1, 32'd10, 32'd10, OP_SUB);
        chk("sub_id", last_id, 1);
        chk("sub_result", last_res, 0);
        chk("sub_flags", last_flg, 4'b0010);

        run_op(1'b1, 32'hFFFF_FFFB, 32'd10, OP_SLT);
        chk("slt_result", last_res, 1);

        run_op(1'b0, 32'hFFFF_FFFF, 32'h1234, 3'b110);
        chk("illegal_err", last_err, 1);
        chk("illegal_result", last_res, 0);
        chk("illegal_flags", last_flg, 4'b0000);
        chk("illegal_exec_ctrl", exec_ctrl_seen, 3'b000);

        // backpressure: hold rsp_ready low while r1 waits
        rsp_ready = 1'b0;
        base = rsp_count;
        issue(1'b0, 32'd3, 32'd4, OP_OR, 1'b1, 20);
        fork
            issue(1'b1, 32'd9, 32'd6, OP_AND, 1'b1, 40);
            begin repeat (6) @(posedge clk); #1 rsp_ready = 1'b1; end
        join
        chk("stall_first_rsp_count", rsp_count, base + 1);
        chk("stall_or_result", last_res, 7);
        wait_count(base + 2);
        chk("stall_and_id", last_id, 1);
        chk("stall_and_flags", last_flg, 4'b0010);

        // both requesters held valid
        grant_log.delete();
        fork
            for (int i = 0; i < 4; i++) issue(1'b0, W'(i + 1), 32'd2, OP_ADD, 1'b1, 60);
            for (int j = 0; j < 4; j++) issue(1'b1, W'(j + 10), 32'd3, OP_SUB, 1'b1, 60);
        join
        wait_idle();
        chk("grant_count", grant_log.size(), 8);
        if (grant_log.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                chk("grant_sequence", grant_log[i], RR_EN ? !grant_log[i-1] : 1'b0);
        end

        // reset while an AND is in EXEC
        base = rsp_count;
        issue(1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_AND, 1'b1, 20);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_count, base);
        run_op(1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_AND);
        chk("and_after_reset", last_res, 32'h0F00_0F00);

        // randomized traffic with random response backpressure
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                if (rand_on) rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        fork
            rand_driver(1'b0);
            rand_driver(1'b1);
        join
        rand_on = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; the ALU ports SHALL use this width.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 r0_valid / r1_valid  in  1  requester 0/1 presents an operation.
REQ-005 r0_ready / r1_ready  out  1  operation accepted this cycle (valid & ready = accept).
REQ-006 r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands.
REQ-007 r0_op / r1_op  in  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 alu_a, alu_b  out  WIDTH  operands driven to the shared ALU; alu_ctrl  out  3  control code driven to the shared ALU.
REQ-009 alu_result  in  WIDTH; alu_overflow, alu_carry, alu_zero, alu_negative  in  1  combinational ALU outputs.
REQ-010 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-011 rsp_id  out  1  requester index; rsp_result  out  WIDTH; rsp_flags  out  4  {overflow,carry,zero,negative}; rsp_err  out  1  illegal opcode.

Function
REQ-012 FSM states SHALL be IDLE, EXEC and RESP.
REQ-013 IDLE: with at least one valid requester, the block SHALL assert ready to exactly one granted requester (combinational from state and valids) and on accept SHALL latch a, b, op and id and go to EXEC.
REQ-014 rX_ready SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester.
REQ-015 EXEC: alu_a/alu_b/alu_ctrl SHALL hold the latched values for one full cycle; at the end of EXEC, alu_result and the four flags SHALL be captured into rsp registers and the state SHALL move to RESP.
REQ-016 RESP: rsp_valid SHALL be 1 with stable rsp_* outputs until rsp_valid & rsp_ready, then the state SHALL return to IDLE in the next cycle.
REQ-017 Latency: accept in cycle N SHALL give rsp_valid=1 in cycle N+2; peak throughput SHALL be one operation per 3 cycles with rsp_ready held high.
REQ-018 Illegal opcodes (100, 110, 111) SHALL be accepted and pass through EXEC, with alu_ctrl driven 000 and alu_a = alu_b = 0; the response SHALL carry rsp_result=0, rsp_flags=0 and rsp_err=1.
REQ-019 alu_a, alu_b and alu_ctrl SHALL retain their last values outside EXEC (no toggling in IDLE or RESP).
REQ-020 A requester deasserting valid before acceptance SHALL lose nothing; no partial capture is permitted.
REQ-021 Stalling rsp_ready SHALL backpressure: no new accept SHALL occur while in RESP.

Reset
REQ-022 When rst_n=0, the state SHALL be IDLE, and r0_ready, r1_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, alu_a, alu_b and alu_ctrl SHALL all be 0, with the round-robin pointer at last_grant=1.
REQ-023 A reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be emitted after release.
REQ-024 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-025 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the grant SHALL go to the requester not named by last_grant, and last_grant SHALL update on every accept.
REQ-026 With ALU_ARB_RR_EN undefined, arbitration SHALL be fixed priority: requester 0 SHALL always win, and no pointer register SHALL exist.
REQ-027 When only one requester is valid, that requester SHALL be granted in both configurations.

Verification
REQ-028 r0 ADD a=5, b=7, rsp_ready=1 -> rsp_valid two cycles after accept with rsp_id=0, rsp_result=12, rsp_flags=0000, rsp_err=0.
REQ-029 r1 SUB a=10, b=10 -> rsp_result=0, rsp_flags=0010 (zero), rsp_id=1; r1 SLT a=-5 (0xFFFFFFFB), b=10 -> rsp_result=1.
REQ-030 r0 and r1 held valid continuously with ALU_ARB_RR_EN -> grants alternate 0,1,0,1; without the macro -> grant is always 0 and r1 never receives ready.
REQ-031 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, r0_ready=r1_ready=0 throughout; the next accept occurs one cycle after the handshake.
REQ-032 r0_op=110 with a=0xFFFFFFFF -> rsp_err=1, rsp_result=0, alu_ctrl=000 during EXEC.
REQ-033 rst_n pulsed low during EXEC of an AND 0xFF00FF00 & 0x0F0F0F0F -> all outputs 0, no rsp_valid after release; next request completes normally with result 0x0F000F00.
